cond_flag_unit: RTL
===================

// Module: cond_flag_unit
// PURPOSE
//  Consumer side of the ALU NZCV flag interface. Holds the architectural NZCV
//  register, written by flag-setting ALU ops. Tracks in-flight flag writers with
//  a pending counter (scoreboard). Evaluates 4-bit ARM condition codes for the
//  issue stage through a valid/ready handshake, returning a registered pass/fail.
// PARAMETERS
//  MAX_PEND  3  max in-flight flag-setting ops tracked (>=1)
//  CW        2  pending-counter width; must satisfy 2**CW > MAX_PEND
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  flag_we       in   1   ALU flag write strobe, one per completed S-op
//  flag_mask     in   4   per-bit write enable {N,Z,C,V}
//  flag_in       in   4   new flags {N,Z,C,V} from ALU
//  pend_inc      in   1   flag-setting op issued this cycle
//  pend_full     out  1   pend_cnt == MAX_PEND; issue must hold S-ops
//  cond_valid    in   1   condition request valid
//  cond_ready    out  1   request accepted when valid & ready
//  cond          in   4   ARM condition field
//  res_valid     out  1   result valid
//  res_ready     in   1   result consumed when valid & ready
//  res_pass      out  1   1 = condition true
//  nzcv          out  4   current flag register {N,Z,C,V}
//  pend_cnt      out  CW  in-flight flag writers
//  err_ovf       out  1   sticky: pend_inc dropped while full
//  err_unf       out  1   sticky: flag_we with no pending writer
// BEHAVIOUR
//  Reset (async, rst_n=0): nzcv=0, pend_cnt=0, res_valid=0, res_pass=0,
//   err_ovf=0, err_unf=0. Any held result is discarded; no partial state kept.
//  Flag write: when flag_we, nzcv[i] <= flag_in[i] for each flag_mask[i]=1;
//   unmasked bits hold. Writes occur regardless of counter state.
//  merged = flag_we ? (flag_in & flag_mask) | (nzcv & ~flag_mask) : nzcv
//   merged is combinational forwarding of this cycle's write.
//  Counter: next = pend_cnt + inc_eff - dec_eff, where
//   dec_eff = flag_we & (pend_cnt != 0);
//   inc_eff = pend_inc & (pend_cnt != MAX_PEND | dec_eff).
//   pend_inc & ~inc_eff sets err_ovf. flag_we & pend_cnt==0 sets err_unf, and
//   the count stays 0. Simultaneous inc and dec with cnt==0 counts as underflow
//   plus increment, giving cnt=1 and err_unf=1.
//  Hazard: cond 4'hE (AL) and 4'hF (NV) never stall. Other codes need
//   eff_pend == 0, where eff_pend = pend_cnt - dec_eff; a pend_inc in the same
//   cycle does not block.
//  cond_ready = (~res_valid | res_ready) & (cond>=4'hE | eff_pend==0).
//   Combinational in cond, so valid-before-ready is allowed.
//  Evaluation on accept uses merged flags. Latency is 1 cycle: res_valid and
//   res_pass are registered.
//   0 EQ Z    1 NE ~Z    2 CS C       3 CC ~C     4 MI N        5 PL ~N
//   6 VS V    7 VC ~V    8 HI C&~Z    9 LS ~C|Z   A GE N==V     B LT N!=V
//   C GT ~Z&(N==V)       D LE Z|(N!=V)            E AL 1        F NV 0
//  Output: res_valid & ~res_ready holds res_pass stable and blocks accept.
//   res_ready with no new accept clears res_valid. Accept while draining gives
//   back-to-back results, 1 per cycle.
//  cond_ready is 0 while rst_n is 0.
// TESTING
//  1. After reset: nzcv=0, pend_cnt=0, res_valid=0. cond=0 (EQ) accepted ->
//     next cycle res_valid=1, res_pass=0. cond=1 (NE) -> res_pass=1.
//  2. flag_we, mask=4'hF, flag_in=4'b0110 (Z,C) -> nzcv=0110.
//     Then HI->0, LS->1, CS->1, GE->1 (N==V==0).
//  3. pend_inc, then cond=EQ held valid -> cond_ready=0 until flag_we.
//     flag_we cycle with flag_in Z=1 -> accepted same cycle, res_pass=1
//     (forwarded).
//  4. pend_inc x3 -> pend_full=1. 4th pend_inc alone -> cnt stays 3, err_ovf=1.
//     pend_inc+flag_we together at full -> cnt stays 3, no new error.
//  5. flag_we with cnt=0 -> err_unf=1, cnt=0. AL/NV accepted while cnt=2 ->
//     res_pass=1/0.
//  6. res_ready=0 for 3 cycles with cond_valid=1 -> res_pass stable,
//     cond_ready=0. rst_n pulse low mid-stall -> res_valid=0 immediately
//     (async), nzcv=0.

Source files
------------

// File: rtl/cond_flag_if.sv
// Bundle between the issue/ALU side and the NZCV flag unit: flag writes,
// pending-writer scoreboard and the condition request/result handshake.
interface cond_flag_if #(
  parameter int unsigned CW = 2
);
  logic          flag_we;
  logic [3:0]    flag_mask;
  logic [3:0]    flag_in;
  logic          pend_inc;
  logic          pend_full;
  logic          cond_valid;
  logic          cond_ready;
  logic [3:0]    cond;
  logic          res_valid;
  logic          res_ready;
  logic          res_pass;
  logic [3:0]    nzcv;
  logic [CW-1:0] pend_cnt;
  logic          err_ovf;
  logic          err_unf;

  modport master (
    output flag_we, flag_mask, flag_in, pend_inc, cond_valid, cond, res_ready,
    input  pend_full, cond_ready, res_valid, res_pass, nzcv, pend_cnt,
           err_ovf, err_unf
  );

  modport slave (
    input  flag_we, flag_mask, flag_in, pend_inc, cond_valid, cond, res_ready,
    output pend_full, cond_ready, res_valid, res_pass, nzcv, pend_cnt,
           err_ovf, err_unf
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register with an in-flight flag-writer scoreboard and a
// one-cycle condition-code evaluator behind a valid/ready handshake.
module cond_flag_unit #(
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned CW       = 2
) (
  input logic        clk,
  input logic        rst_n,
  cond_flag_if.slave bus
);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PEND);

  logic [3:0]    nzcv_q, nzcv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          rv_q, rv_d;
  logic          rp_q, rp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [3:0]    merged;
  logic          dec_eff;
  logic          inc_eff;
  logic [CW-1:0] eff_pend;
  logic          hazard_free;
  logic          ready;
  logic          accept;

  // ARM condition evaluation on {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cf;
      4'h3:    r = ~cf;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cf & ~z;
      4'h9:    r = ~cf | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Forwarded flags and scoreboard bookkeeping for this cycle
  always_comb begin
    merged      = bus.flag_we ? ((bus.flag_in & bus.flag_mask) | (nzcv_q & ~bus.flag_mask))
                              : nzcv_q;
    dec_eff     = bus.flag_we & (cnt_q != '0);
    inc_eff     = bus.pend_inc & ((cnt_q != FULL_CNT) | dec_eff);
    eff_pend    = cnt_q - CW'(dec_eff);
    hazard_free = (bus.cond >= 4'hE) | (eff_pend == '0);
    ready       = rst_n & (~rv_q | bus.res_ready) & hazard_free;
    accept      = bus.cond_valid & ready;
  end

  always_comb begin
    nzcv_d = merged;
    cnt_d  = cnt_q + CW'(inc_eff) - CW'(dec_eff);
    full_d = (cnt_d == FULL_CNT);
    rv_d   = rv_q;
    rp_d   = rp_q;
    ovf_d  = ovf_q | (bus.pend_inc & ~inc_eff);
    unf_d  = unf_q | (bus.flag_we & (cnt_q == '0));
    if (accept) begin
      rv_d = 1'b1;
      rp_d = cond_pass(bus.cond, merged);
    end else if (bus.res_ready) begin
      rv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      rv_q   <= 1'b0;
      rp_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      nzcv_q <= nzcv_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      rv_q   <= rv_d;
      rp_q   <= rp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign bus.cond_ready = ready;
  assign bus.nzcv       = nzcv_q;
  assign bus.pend_cnt   = cnt_q;
  assign bus.pend_full  = full_q;
  assign bus.res_valid  = rv_q;
  assign bus.res_pass   = rp_q;
  assign bus.err_ovf    = ovf_q;
  assign bus.err_unf    = unf_q;
endmodule
